mu_result_collector: RTL and testbench

- Downstream stage of the matrix-multiply unit (MU).
- Captures the four 18-bit lane results on every one-cycle arthmetic_finish pulse, buffering one full result matrix of LANES x COLS words.
- Drains the matrix serially over a valid/ready stream to the next consumer (output memory or serial link).
- Flags any MU completion that arrives while a drain is still in progress.

---
 rtl/mu_pkg.sv | 21 ++
 rtl/mu_result_buffer.sv | 32 +++
 rtl/mu_result_collector.sv | 109 ++++++++++
 tb/tb_mu_result_collector.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/mu_pkg.sv
// Shared MU parameters, collector FSM states and buffer indexing helper.
package mu_pkg;

  localparam int RES_W     = 18;
  localparam int LANES     = 4;
  localparam int COLS      = 4;
  localparam int BUF_DEPTH = LANES * COLS;
  localparam int IDX_W     = $clog2(BUF_DEPTH);
  localparam int COL_W     = (COLS > 1) ? $clog2(COLS) : 1;

  typedef enum logic {
    COLLECT = 1'b0,
    DRAIN   = 1'b1
  } state_t;

  // Buffer layout is column-major: word index = col*LANES + lane.
  function automatic logic [IDX_W-1:0] buf_idx(input logic [COL_W-1:0] col, input int lane);
    return IDX_W'(int'(col) * LANES + lane);
  endfunction

endpackage

// File: rtl/mu_result_buffer.sv
// BUF_DEPTH x RES_W register file: one full-column write port, one registered read port.
module mu_result_buffer
  import mu_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_wr_en,
  input  logic [COL_W-1:0]             i_wr_col,
  input  logic [LANES-1:0][RES_W-1:0]  i_wr_data,
  input  logic                         i_rd_en,
  input  logic [IDX_W-1:0]             i_rd_addr,
  output logic [RES_W-1:0]             o_rd_data
);

  logic [RES_W-1:0] r_mem [BUF_DEPTH];
  logic [RES_W-1:0] r_rd_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) r_mem[i] <= '0;
      r_rd_data <= '0;
    end else begin
      if (i_wr_en) begin
        for (int l = 0; l < LANES; l++) r_mem[buf_idx(i_wr_col, l)] <= i_wr_data[l];
      end
      if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/mu_result_collector.sv
// Collects COLS columns of MU lane results into a buffer, then drains them one word at a time.
module mu_result_collector
  import mu_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [RES_W-1:0]  result_1,
  input  logic [RES_W-1:0]  result_2,
  input  logic [RES_W-1:0]  result_3,
  input  logic [RES_W-1:0]  result_4,
  input  logic              arthmetic_finish,
  output logic [RES_W-1:0]  out_data,
  output logic [IDX_W-1:0]  out_index,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              matrix_done,
  output logic              collecting,
  output logic              overflow_err,
  output state_t            dbg_state
);

  // Stream: a word transfers on a rising clk where out_valid && out_ready;
  // out_valid never drops and out_data/out_index never change until that transfer.

  state_t                       r_state;
  logic [COL_W-1:0]             r_col_cnt;
  logic [IDX_W-1:0]             r_rd_idx;
  logic                         r_matrix_done;
  logic                         r_overflow_err;

  state_t                       w_state_nxt;
  logic [COL_W-1:0]             w_col_nxt;
  logic [IDX_W-1:0]             w_rd_idx_nxt;
  logic                         w_wr_en;
  logic                         w_done_nxt;
  logic                         w_drop;
  logic [LANES-1:0][RES_W-1:0]  w_wr_data;

  assign w_wr_data = {result_4, result_3, result_2, result_1};
  assign w_drop    = arthmetic_finish && (r_state == DRAIN);

  always_comb begin
    w_state_nxt  = r_state;
    w_col_nxt    = r_col_cnt;
    w_rd_idx_nxt = r_rd_idx;
    w_wr_en      = 1'b0;
    w_done_nxt   = 1'b0;
    case (r_state)
      COLLECT: begin
        if (arthmetic_finish) begin
          w_wr_en = 1'b1;
          if (r_col_cnt == COL_W'(COLS - 1)) begin
            w_col_nxt    = '0;
            w_rd_idx_nxt = '0;
            w_state_nxt  = DRAIN;
          end else begin
            w_col_nxt = r_col_cnt + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (out_ready) begin
          w_rd_idx_nxt = r_rd_idx + 1'b1;
          if (r_rd_idx == IDX_W'(BUF_DEPTH - 1)) begin
            w_state_nxt = COLLECT;
            w_done_nxt  = 1'b1;
          end
        end
      end
      default: w_state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= COLLECT;
      r_col_cnt      <= '0;
      r_rd_idx       <= '0;
      r_matrix_done  <= 1'b0;
      r_overflow_err <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_col_cnt     <= w_col_nxt;
      r_rd_idx      <= w_rd_idx_nxt;
      r_matrix_done <= w_done_nxt;
      if (w_drop) r_overflow_err <= 1'b1;
    end
  end

  // Read address is the next index so out_data lines up with out_index one edge later.
  mu_result_buffer u_buf (
    .clk       (clk),
    .rst_n     (reset_n),
    .i_wr_en   (w_wr_en),
    .i_wr_col  (r_col_cnt),
    .i_wr_data (w_wr_data),
    .i_rd_en   (w_state_nxt == DRAIN),
    .i_rd_addr (w_rd_idx_nxt),
    .o_rd_data (out_data)
  );

  assign out_index    = r_rd_idx;
  assign out_valid    = (r_state == DRAIN);
  assign matrix_done  = r_matrix_done;
  assign collecting   = (r_state == COLLECT);
  assign overflow_err = r_overflow_err;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_mu_result_collector.sv
// Directed bench for mu_result_collector with an expected-word queue.
module tb_mu_result_collector;
  import mu_pkg::*;

  logic              clk;
  logic              reset_n;
  logic [RES_W-1:0]  result_1, result_2, result_3, result_4;
  logic              arthmetic_finish;
  logic [RES_W-1:0]  out_data;
  logic [IDX_W-1:0]  out_index;
  logic              out_valid;
  logic              out_ready;
  logic              matrix_done;
  logic              collecting;
  logic              overflow_err;
  state_t            dbg_state;

  logic [RES_W-1:0]  exp_q[$];
  int                n_vec = 0;
  int                n_err = 0;

  localparam logic [RES_W-1:0] MAXV = 18'h3FFFF;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  mu_result_collector dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .result_1         (result_1),
    .result_2         (result_2),
    .result_3         (result_3),
    .result_4         (result_4),
    .arthmetic_finish (arthmetic_finish),
    .out_data         (out_data),
    .out_index        (out_index),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .matrix_done      (matrix_done),
    .collecting       (collecting),
    .overflow_err     (overflow_err),
    .dbg_state        (dbg_state)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver: one finish pulse, expected words queued in buffer order
  task automatic pulse(input logic [RES_W-1:0] a, b, c, d);
    result_1 = a; result_2 = b; result_3 = c; result_4 = d;
    arthmetic_finish = 1'b1;
    exp_q.push_back(a); exp_q.push_back(b); exp_q.push_back(c); exp_q.push_back(d);
    tick();
    arthmetic_finish = 1'b0;
  endtask

  task automatic fill(input int first_col, input bit use_max);
    for (int c = first_col; c < COLS; c++) begin
      if (c > first_col) repeat (7) tick();
      if (use_max) pulse(MAXV, MAXV, MAXV, MAXV);
      else pulse(RES_W'(100*c+1), RES_W'(100*c+2), RES_W'(100*c+3), RES_W'(100*c+4));
      if (c < COLS-1) begin
        check_eq("collect_valid", 32'(out_valid), 32'd0);
        check_eq("collecting", 32'(collecting), 32'd1);
      end
    end
  endtask

  // mode 0: out_ready always 1, mode 1: toggles 1/0 starting at 1
  task automatic drain(input int mode, input int inject_idx, input int reset_idx, input int exp_cycles);
    int  cyc = 0;
    int  idx_exp = 0;
    bit  aborted = 0;
    bit  injected = 0;
    check_eq("drain_state", 32'(dbg_state), 32'(DRAIN));
    while (exp_q.size() > 0 && cyc < 100 && !aborted) begin
      arthmetic_finish = 1'b0;
      out_ready = (mode == 0) ? 1'b1 : ((cyc % 2) == 0);
      check_eq("drain_valid", 32'(out_valid), 32'd1);
      if (reset_idx == idx_exp) begin
        #2 reset_n = 1'b0;
        #1;
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_data", 32'(out_data), 32'd0);
        check_eq("rst_index", 32'(out_index), 32'd0);
        check_eq("rst_done", 32'(matrix_done), 32'd0);
        check_eq("rst_collecting", 32'(collecting), 32'd1);
        check_eq("rst_overflow", 32'(overflow_err), 32'd0);
        #2 reset_n = 1'b1;
        exp_q.delete();
        out_ready = 1'b0;
        aborted = 1;
        tick();
      end else begin
        if (inject_idx == idx_exp && !injected) begin
          result_1 = MAXV; result_2 = MAXV; result_3 = MAXV; result_4 = MAXV;
          arthmetic_finish = 1'b1;
          injected = 1;
        end
        check_eq("drain_data", 32'(out_data), 32'(exp_q[0]));
        check_eq("drain_index", 32'(out_index), 32'(idx_exp));
        if (out_ready) begin
          void'(exp_q.pop_front());
          idx_exp++;
        end
        tick();
        cyc++;
      end
    end
    arthmetic_finish = 1'b0;
    if (cyc >= 100) check_eq("drain_timeout", 32'(cyc), 32'(exp_cycles));
    else if (!aborted) begin
      check_eq("drain_cycles", 32'(cyc), 32'(exp_cycles));
      check_eq("done_pulse", 32'(matrix_done), 32'd1);
      check_eq("done_valid", 32'(out_valid), 32'd0);
      check_eq("done_collecting", 32'(collecting), 32'd1);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    result_1 = '0; result_2 = '0; result_3 = '0; result_4 = '0;
    arthmetic_finish = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_valid", 32'(out_valid), 32'd0);
    check_eq("reset_data", 32'(out_data), 32'd0);
    check_eq("reset_index", 32'(out_index), 32'd0);
    check_eq("reset_done", 32'(matrix_done), 32'd0);
    check_eq("reset_collecting", 32'(collecting), 32'd1);
    check_eq("reset_overflow", 32'(overflow_err), 32'd0);
    check_eq("reset_state", 32'(dbg_state), 32'(COLLECT));
    reset_n = 1'b1;
    tick();

    // back-to-back drain
    fill(0, 0);
    drain(0, -1, -1, 16);
    tick();
    check_eq("done_one_cycle", 32'(matrix_done), 32'd0);
    check_eq("overflow_clean", 32'(overflow_err), 32'd0);

    // throttled drain
    tick();
    fill(0, 0);
    drain(1, -1, -1, 31);
    check_eq("overflow_clean2", 32'(overflow_err), 32'd0);

    // dropped finish during drain at index 5
    tick();
    fill(0, 0);
    drain(0, 5, -1, 16);
    check_eq("overflow_set", 32'(overflow_err), 32'd1);

    // finish in the matrix_done cycle becomes column 0 of the next matrix
    pulse(18'd7, 18'd8, 18'd9, 18'd10);
    repeat (7) tick();
    fill(1, 0);
    drain(0, -1, -1, 16);
    check_eq("overflow_sticky", 32'(overflow_err), 32'd1);

    // async reset at drain index 9, then a fresh max-value matrix
    tick();
    fill(0, 0);
    drain(0, -1, 9, 0);
    check_eq("post_rst_state", 32'(dbg_state), 32'(COLLECT));
    fill(0, 1);
    drain(0, -1, -1, 16);
    check_eq("overflow_after_rst", 32'(overflow_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
